mlp_result_drain: RTL

//  Downstream of the PE array. Collects the 2-row results the array emits each round into a
//  16x16 x 16-bit result matrix. On command, streams the matrix out as 32-bit words over a

---
 rtl/mlp_pkg.sv | 22 ++
 rtl/mlp_result_drain_if.sv | 16 +
 rtl/mlp_relu.sv | 13 +
 rtl/mlp_result_drain.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared types and constants for the MLP result drain.
//   DATA_W / DIM / ROWS_PER_ROUND / OUT_W : matrix and stream geometry
//   elem_t        : one matrix element
//   round_t       : [r][c] payload of one PE-array round (r=0 is the even row)
//   drain_state_e : drain controller states
package mlp_pkg;

    localparam int unsigned DATA_W         = 16;
    localparam int unsigned DIM            = 16;
    localparam int unsigned ROWS_PER_ROUND = 2;
    localparam int unsigned OUT_W          = 32;

    localparam int unsigned NUM_ROUNDS = DIM / ROWS_PER_ROUND;
    localparam int unsigned NUM_WORDS  = (DIM * DIM * DATA_W) / OUT_W;
    localparam int unsigned K_W        = $clog2(NUM_WORDS);

    typedef logic [DATA_W-1:0] elem_t;
    typedef elem_t [ROWS_PER_ROUND-1:0][DIM-1:0] round_t;

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} drain_state_e;

endpackage

// File: rtl/mlp_result_drain_if.sv
// Result stream of the drain: valid/ready handshake carrying two elements per word.
//   valid   : payload valid (driven by master)
//   ready   : consumer accepts the current word (driven by slave)
//   payload : {elem[2k+1], elem[2k]}
// Modports: master = drain side, slave = consumer side.
interface mlp_result_drain_if;
    import mlp_pkg::*;

    logic             valid;
    logic             ready;
    logic [OUT_W-1:0] payload;

    modport master (output valid, output payload, input ready);
    modport slave  (input valid, input payload, output ready);

endinterface

// File: rtl/mlp_relu.sv
// Signed ReLU on one matrix element: negative values become zero.
//   elem_i : raw element
//   elem_o : max(elem_i, 0) in two's complement
module mlp_relu
    import mlp_pkg::*;
(
    input  elem_t elem_i,
    output elem_t elem_o
);

    assign elem_o = elem_i[DATA_W-1] ? '0 : elem_i;

endmodule

// File: rtl/mlp_result_drain.sv
// Collects PE-array rounds (two rows each) into a 16x16 result matrix and, on command,
// streams it out row-major as 32-bit words over a back-pressure-safe valid/ready handshake.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   round_valid_i     : round_number_i / round_data_i valid this cycle
//   round_number_i    : round n writes matrix rows 2n and 2n+1
//   round_data_i      : [r][c] elements of the round
//   drain_start_i     : request to stream the matrix (honoured only when already full)
//   result_if         : output word stream (master)
//   matrix_full_o     : every round written since the last drain
//   busy_o            : draining
//   err_drop_o        : sticky, a round arrived while draining and was dropped
// Build option: define MLP_DRAIN_RELU_EN to apply signed ReLU on the output path.
module mlp_result_drain
    import mlp_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    round_valid_i,
    input  logic [2:0]              round_number_i,
    input  round_t                  round_data_i,
    input  logic                    drain_start_i,
    mlp_result_drain_if.master      result_if,
    output logic                    matrix_full_o,
    output logic                    busy_o,
    output logic                    err_drop_o
);

    localparam logic [K_W-1:0] LastWord = K_W'(NUM_WORDS - 1);

    drain_state_e          state_q, state_d;
    elem_t                 mem_q [DIM][DIM];
    logic [NUM_ROUNDS-1:0] bitmap_q, bitmap_d;
    logic                  full_q;
    logic [K_W-1:0]        k_q, k_d;
    logic                  err_q, err_d;
    logic                  wr_en;
    logic                  start_ok;
    logic                  hs;

    // full_q is already registered, so a start coinciding with the final write is ignored.
    assign start_ok = drain_start_i && full_q && (state_q != DRAIN);
    assign hs       = (state_q == DRAIN) && result_if.ready;

    always_comb begin
        state_d  = state_q;
        bitmap_d = bitmap_q;
        k_d      = k_q;
        err_d    = err_q;
        wr_en    = 1'b0;
        unique case (state_q)
            IDLE, COLLECT: begin
                if (round_valid_i) begin
                    wr_en                    = 1'b1;
                    bitmap_d[round_number_i] = 1'b1;
                    state_d                  = COLLECT;
                end
                if (start_ok) begin
                    state_d = DRAIN;
                    k_d     = '0;
                    err_d   = 1'b0;
                end
            end
            DRAIN: begin
                if (round_valid_i) begin
                    err_d = 1'b1;
                end
                if (hs) begin
                    k_d = k_q + 1'b1;
                    if (k_q == LastWord) begin
                        state_d  = IDLE;
                        bitmap_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bitmap_q <= '0;
            full_q   <= 1'b0;
            k_q      <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitmap_q <= bitmap_d;
            full_q   <= &bitmap_d;
            k_q      <= k_d;
            err_q    <= err_d;
        end
    end

    // Round n lands on rows {n,0} and {n,1}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    mem_q[r][c] <= '0;
                end
            end
        end else if (wr_en) begin
            for (int c = 0; c < DIM; c++) begin
                mem_q[{round_number_i, 1'b0}][c] <= round_data_i[0][c];
                mem_q[{round_number_i, 1'b1}][c] <= round_data_i[1][c];
            end
        end
    end

    // Word k holds elements 2k and 2k+1: row k[6:3], columns {k[2:0],0} and {k[2:0],1}.
    elem_t elem_lo_raw, elem_hi_raw, elem_lo, elem_hi;

    assign elem_lo_raw = mem_q[k_q[6:3]][{k_q[2:0], 1'b0}];
    assign elem_hi_raw = mem_q[k_q[6:3]][{k_q[2:0], 1'b1}];

`ifdef MLP_DRAIN_RELU_EN
    mlp_relu u_relu_lo (
        .elem_i (elem_lo_raw),
        .elem_o (elem_lo)
    );
    mlp_relu u_relu_hi (
        .elem_i (elem_hi_raw),
        .elem_o (elem_hi)
    );
`else
    assign elem_lo = elem_lo_raw;
    assign elem_hi = elem_hi_raw;
`endif

    assign result_if.valid   = (state_q == DRAIN);
    assign result_if.payload = result_if.valid ? {elem_hi, elem_lo} : '0;
    assign matrix_full_o     = full_q;
    assign busy_o            = (state_q == DRAIN);
    assign err_drop_o        = err_q;

endmodule
